// File: rtl/serial_tx_queue.sv
// serial_tx_queue: byte FIFO feeding a UART transmitter (8N1, idle-high line).
// Defining UART_TX_PARITY_EN adds an even-parity bit between data and stop (8E1).
module serial_tx_queue #(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    data_in,
    input  logic                          data_in_valid,
    output logic                          data_in_ready,
    output logic                          serial_out,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int SYMBOL_CYCLES = CLOCK_FREQ / BAUD_RATE;
    localparam int PTR_W         = $clog2(FIFO_DEPTH);
    localparam int CNT_W         = (SYMBOL_CYCLES > 1) ? $clog2(SYMBOL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST  = CNT_W'(SYMBOL_CYCLES - 1);
    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]   ZERO_COUNT = (PTR_W + 1)'(0);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd4
    } state_t;
`endif

    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    state_t           r_state;
    logic [CNT_W-1:0] r_baud_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_serial;
`ifdef UART_TX_PARITY_EN
    logic             r_parity;
`endif

    logic       w_full;
    logic       w_push;
    logic       w_baud_done;
    logic       w_pop;
    logic [7:0] w_head;

    assign w_full      = (r_count == FULL_COUNT);
    assign w_push      = data_in_valid && !w_full;
    assign w_baud_done = (r_baud_cnt == BAUD_LAST);
    // A pop happens only when the FSM is about to start a frame: from idle, or straight out of a stop bit.
    assign w_pop       = (r_count != ZERO_COUNT) &&
                         ((r_state == S_IDLE) || ((r_state == S_STOP) && w_baud_done));
    assign w_head      = r_mem[r_rd_ptr];

    assign data_in_ready = !w_full;
    assign serial_out    = r_serial;
    assign busy          = (r_state != S_IDLE) || (r_count != ZERO_COUNT);
    assign fifo_count    = r_count;

    // Queue storage: written only on an accepted push, so queued bytes never follow data_in.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    // Queue pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= ZERO_COUNT;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Transmit FSM; serial_out is registered and each state holds its bit for SYMBOL_CYCLES.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_baud_cnt <= {CNT_W{1'b0}};
            r_bit_idx  <= 3'd0;
            r_shift    <= 8'h00;
            r_serial   <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_baud_cnt <= {CNT_W{1'b0}};
                    if (w_pop) begin
                        r_shift  <= w_head;
`ifdef UART_TX_PARITY_EN
                        r_parity <= even_parity(w_head);
`endif
                        r_state  <= S_START;
                        r_serial <= 1'b0;
                    end else begin
                        r_serial <= 1'b1;
                    end
                end
                S_START: begin
                    if (w_baud_done) begin
                        r_baud_cnt <= {CNT_W{1'b0}};
                        r_bit_idx  <= 3'd0;
                        r_serial   <= r_shift[0];
                        r_shift    <= {1'b0, r_shift[7:1]};
                        r_state    <= S_DATA;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (w_baud_done) begin
                        r_baud_cnt <= {CNT_W{1'b0}};
                        if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            r_serial <= r_parity;
                            r_state  <= S_PARITY;
`else
                            r_serial <= 1'b1;
                            r_state  <= S_STOP;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_serial  <= r_shift[0];
                            r_shift   <= {1'b0, r_shift[7:1]};
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + CNT_W'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (w_baud_done) begin
                        r_baud_cnt <= {CNT_W{1'b0}};
                        r_serial   <= 1'b1;
                        r_state    <= S_STOP;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + CNT_W'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (w_baud_done) begin
                        r_baud_cnt <= {CNT_W{1'b0}};
                        if (w_pop) begin
                            r_shift  <= w_head;
`ifdef UART_TX_PARITY_EN
                            r_parity <= even_parity(w_head);
`endif
                            r_serial <= 1'b0;
                            r_state  <= S_START;
                        end else begin
                            r_serial <= 1'b1;
                            r_state  <= S_IDLE;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_baud_cnt <= {CNT_W{1'b0}};
                    r_serial   <= 1'b1;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_tx_queue.sv
// Scoreboard bench for serial_tx_queue: accepted bytes are queued, a line decoder pops and compares.
module tb_serial_tx_queue;

    localparam int SYM   = 4;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_in;
    logic       data_in_valid;
    logic       data_in_ready;
    logic       serial_out;
    logic       busy;
    logic [2:0] fifo_count;

    int errors = 0;
    int checks = 0;

    logic [7:0] sb [$];

    bit         rx_active = 1'b0;
    int         rx_cnt;
    int         rx_b;
    logic [7:0] rx_byte;
    logic [7:0] rx_exp;

    serial_tx_queue #(
        .CLOCK_FREQ (40),
        .BAUD_RATE  (10),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .data_in_ready (data_in_ready),
        .serial_out    (serial_out),
        .busy          (busy),
        .fifo_count    (fifo_count)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // Line decoder: samples each bit in the middle of its 4-cycle symbol and checks against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            rx_active = 1'b0;
        end else if (!rx_active) begin
            if (serial_out === 1'b0) begin
                rx_active = 1'b1;
                rx_cnt    = 0;
                rx_byte   = 8'h00;
            end
        end else begin
            rx_cnt++;
            if ((rx_cnt % SYM) == 2) begin
                rx_b = rx_cnt / SYM;
                if (rx_b == 0) begin
                    checks++;
                    if (serial_out !== 1'b0) begin
                        errors++;
                        $display("FAIL rx_start_bit got=%b exp=0", serial_out);
                    end
                end else if (rx_b >= 1 && rx_b <= 8) begin
                    rx_byte[rx_b-1] = serial_out;
`ifdef UART_TX_PARITY_EN
                end else if (rx_b == 9) begin
                    checks++;
                    if (serial_out !== ^rx_byte) begin
                        errors++;
                        $display("FAIL rx_parity got=%b exp=%b", serial_out, ^rx_byte);
                    end
`endif
                end else if (rx_b == FRAME_BITS - 1) begin
                    checks++;
                    if (serial_out !== 1'b1) begin
                        errors++;
                        $display("FAIL rx_stop_bit got=%b exp=1", serial_out);
                    end
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL rx_unexpected_byte got=%h exp=none", rx_byte);
                    end else begin
                        rx_exp = sb.pop_front();
                        if (rx_byte !== rx_exp) begin
                            errors++;
                            $display("FAIL rx_byte got=%h exp=%h", rx_byte, rx_exp);
                        end
                    end
                    rx_active = 1'b0;
                end
            end
        end
    end

    // Present a byte for one edge; acc reports whether that edge accepts it. Returns at the next negedge.
    task automatic offer(input logic [7:0] b, output bit acc);
        data_in       = b;
        data_in_valid = 1'b1;
        acc           = data_in_ready;
        if (acc) sb.push_back(b);
        @(negedge clk);
    endtask

    task automatic wait_idle(input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (!busy && !rx_active) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++;
        if (serial_out !== 1'b1) begin errors++; $display("FAIL reset_serial_out got=%b exp=1", serial_out); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++;
        if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_fifo_count got=%0d exp=0", fifo_count); end
        checks++;
        if (data_in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", data_in_ready); end
        data_in       = 8'h99;
        data_in_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (fifo_count !== 3'd0) begin errors++; $display("FAIL push_in_reset got=%0d exp=0", fifo_count); end
        data_in_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (fifo_count !== 3'd0 || serial_out !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL after_release got=cnt%0d/line%b/busy%b exp=cnt0/line1/busy0", fifo_count, serial_out, busy);
        end
    endtask

    task automatic test_single;
        logic [7:0]  b;
        logic [10:0] fr;
        bit          acc;
        bit          ok;
        b  = 8'hA5;
        fr = 11'h7FF;
        fr[0] = 1'b0;
        for (int i = 0; i < 8; i++) fr[i+1] = b[i];
        if (FRAME_BITS == 11) fr[9] = ^b;
        offer(b, acc);
        data_in_valid = 1'b0;
        checks++;
        if (acc !== 1'b1) begin errors++; $display("FAIL single_accept got=%b exp=1", acc); end
        checks++;
        if (fifo_count !== 3'd1 || serial_out !== 1'b1) begin
            errors++;
            $display("FAIL single_edge_n got=cnt%0d/line%b exp=cnt1/line1", fifo_count, serial_out);
        end
        for (int k = 0; k < FRAME_BITS * SYM; k++) begin
            @(negedge clk);
            checks++;
            if (serial_out !== fr[k/SYM]) begin
                errors++;
                $display("FAIL single_wave cycle=%0d got=%b exp=%b", k, serial_out, fr[k/SYM]);
            end
            if (k == 0) begin
                checks++;
                if (fifo_count !== 3'd0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL single_pop got=cnt%0d/busy%b exp=cnt0/busy1", fifo_count, busy);
                end
            end
        end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_in_stop got=%b exp=1", busy); end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || serial_out !== 1'b1) begin
            errors++;
            $display("FAIL single_after_stop got=busy%b/line%b exp=busy0/line1", busy, serial_out);
        end
        wait_idle(20, ok);
        checks++;
        if (!ok || sb.size() != 0) begin errors++; $display("FAIL single_drain got=left%0d exp=left0", sb.size()); end
    endtask

    task automatic test_back_to_back;
        bit acc0;
        bit acc1;
        bit ok;
        offer(8'h00, acc0);
        offer(8'hFF, acc1);
        data_in_valid = 1'b0;
        checks++;
        if (!acc0 || !acc1) begin errors++; $display("FAIL b2b_accept got=%b%b exp=11", acc0, acc1); end
        checks++;
        if (fifo_count !== 3'd1 || serial_out !== 1'b0) begin
            errors++;
            $display("FAIL b2b_push_pop got=cnt%0d/line%b exp=cnt1/line0", fifo_count, serial_out);
        end
        repeat (FRAME_BITS * SYM - 1) @(negedge clk);
        checks++;
        if (serial_out !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_last_stop got=line%b/busy%b exp=line1/busy1", serial_out, busy);
        end
        @(negedge clk);
        checks++;
        if (serial_out !== 1'b0) begin errors++; $display("FAIL b2b_second_start got=%b exp=0", serial_out); end
        wait_idle(FRAME_BITS * SYM + 20, ok);
        checks++;
        if (!ok || sb.size() != 0) begin errors++; $display("FAIL b2b_drain got=left%0d exp=left0", sb.size()); end
    endtask

    task automatic test_full;
        logic [7:0] nb;
        int         n_acc;
        int         edge6;
        bit         acc;
        bit         ok;
        nb    = 8'h01;
        n_acc = 0;
        edge6 = -1;
        for (int i = 1; i <= 200 && nb <= 8'h06; i++) begin
            if (fifo_count == 3'd4) begin
                checks++;
                if (data_in_ready !== 1'b0) begin errors++; $display("FAIL full_ready got=%b exp=0", data_in_ready); end
            end
            offer(nb, acc);
            if (acc) begin
                n_acc++;
                if (nb == 8'h06) edge6 = i;
                nb = nb + 8'd1;
                if (n_acc == 5) begin
                    checks++;
                    if (fifo_count !== 3'd4 || data_in_ready !== 1'b0) begin
                        errors++;
                        $display("FAIL full_reached got=cnt%0d/ready%b exp=cnt4/ready0", fifo_count, data_in_ready);
                    end
                end
            end
        end
        data_in_valid = 1'b0;
        checks++;
        if (n_acc != 6) begin errors++; $display("FAIL full_accept_count got=%0d exp=6", n_acc); end
        checks++;
        if (edge6 != FRAME_BITS * SYM + 3) begin
            errors++;
            $display("FAIL full_sixth_edge got=%0d exp=%0d", edge6, FRAME_BITS * SYM + 3);
        end
        wait_idle(6 * FRAME_BITS * SYM + 50, ok);
        checks++;
        if (!ok || sb.size() != 0) begin errors++; $display("FAIL full_drain got=left%0d exp=left0", sb.size()); end
    endtask

    task automatic test_wrap;
        logic [7:0] b;
        logic [2:0] max_cnt;
        int         gap;
        bit         acc;
        bit         ok;
        max_cnt = 3'd0;
        for (int k = 0; k < 12; k++) begin
            b   = 8'h10 + 8'(k);
            gap = int'($urandom_range(0, 3));
            data_in_valid = 1'b0;
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                if (fifo_count > max_cnt) max_cnt = fifo_count;
            end
            acc = 1'b0;
            for (int t = 0; t < 200 && !acc; t++) begin
                offer(b, acc);
                if (fifo_count > max_cnt) max_cnt = fifo_count;
            end
            checks++;
            if (!acc) begin errors++; $display("FAIL wrap_accept_timeout got=none exp=%h", b); end
        end
        data_in_valid = 1'b0;
        wait_idle(12 * FRAME_BITS * SYM + 50, ok);
        checks++;
        if (max_cnt > 3'd4) begin errors++; $display("FAIL wrap_max_count got=%0d exp<=4", max_cnt); end
        checks++;
        if (!ok || sb.size() != 0) begin errors++; $display("FAIL wrap_drain got=left%0d exp=left0", sb.size()); end
    endtask

    task automatic test_reset_mid_frame;
        bit a0;
        bit a1;
        bit a2;
        offer(8'hA5, a0);
        offer(8'h5A, a1);
        offer(8'h77, a2);
        data_in_valid = 1'b0;
        checks++;
        if (!a0 || !a1 || !a2) begin errors++; $display("FAIL rstmid_accept got=%b%b%b exp=111", a0, a1, a2); end
        repeat (16) @(negedge clk);
        checks++;
        if (serial_out !== 1'b0 || fifo_count !== 3'd2) begin
            errors++;
            $display("FAIL rstmid_bit3 got=line%b/cnt%0d exp=line0/cnt2", serial_out, fifo_count);
        end
        #2;
        rst = 1'b0;
        sb.delete();
        #1;
        checks++;
        if (serial_out !== 1'b1) begin errors++; $display("FAIL rstmid_line got=%b exp=1", serial_out); end
        checks++;
        if (fifo_count !== 3'd0 || busy !== 1'b0 || data_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_state got=cnt%0d/busy%b/ready%b exp=cnt0/busy0/ready1", fifo_count, busy, data_in_ready);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            checks++;
            if (serial_out !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_after cycle=%0d got=line%b/busy%b exp=line1/busy0", k, serial_out, busy);
            end
        end
    endtask

    initial begin
        rst           = 1'b0;
        data_in       = 8'h00;
        data_in_valid = 1'b0;
        test_reset;
        test_single;
        test_back_to_back;
        test_full;
        test_wrap;
        test_reset_mid_frame;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_tx_queue.md
SERIAL_TX_QUEUE -- requirements
Module: serial_tx_queue

Interface
REQ-001 SHALL have parameter CLOCK_FREQ, default 50_000_000: clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200: serial bit rate.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8: byte queue depth, power of two, minimum 2.
REQ-004 SHALL have port clk  input  1  single clock; all state on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port data_in  input  8  byte to transmit.
REQ-007 SHALL have port data_in_valid  input  1  data_in holds a byte for the queue.
REQ-008 SHALL have port data_in_ready  output  1  queue can accept a byte this cycle.
REQ-009 SHALL have port serial_out  output  1  UART line, idle high, registered.
REQ-010 SHALL have port busy  output  1  a frame is on the line or the queue is non-empty.
REQ-011 SHALL have port fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes queued, excluding the byte in flight.

Function
REQ-012 SHALL define SYMBOL_CYCLES = CLOCK_FREQ/BAUD_RATE, integer-truncated, with each bit held exactly SYMBOL_CYCLES cycles.
REQ-013 SHALL accept a byte on any rising edge where data_in_valid and data_in_ready are both 1.
REQ-014 SHALL drive data_in_ready = (fifo_count != FIFO_DEPTH), combinationally from registered count, with no dependence on data_in_valid.
REQ-015 SHALL NOT accept a push while full, even if a pop occurs the same cycle.
REQ-016 SHALL leave fifo_count unchanged on a simultaneous push and pop.
REQ-017 SHALL store the FIFO pointers modulo FIFO_DEPTH; wrap-around SHALL NOT corrupt order (strict FIFO).
REQ-018 SHALL implement FSM states IDLE, START, DATA, STOP, plus PARITY per REQ-030.
REQ-019 SHALL hold serial_out = 1 in IDLE.
REQ-020 SHALL, in IDLE with fifo_count > 0, pop the head byte into a shift register on the next edge, enter START and drive serial_out = 0 on that edge.
REQ-021 SHALL give push-to-line latency: byte accepted at edge N into an empty, idle block -> serial_out falls at edge N+1.
REQ-022 SHALL transmit data LSB first in DATA, 8 bits, using a 3-bit bit index.
REQ-023 SHALL drive serial_out = 1 in STOP for SYMBOL_CYCLES.
REQ-024 SHALL, at the end of STOP, go directly to START if fifo_count > 0, with no idle cycle between frames; otherwise it SHALL go to IDLE.
REQ-025 SHALL drive busy = (state != IDLE) || (fifo_count != 0).
REQ-026 SHALL leave data_in sampled only on accept; it SHALL NOT change a byte already queued or in flight.

Reset
REQ-027 SHALL, on rst = 0, asynchronously force state to IDLE, serial_out = 1, FIFO pointers and fifo_count = 0, busy = 0, baud counter = 0, bit index = 0, and data_in_ready = 1.
REQ-028 SHALL abandon a frame interrupted mid-transmission by reset, with the line returning high immediately and the queued bytes discarded.
REQ-029 SHALL begin operation on the first rising edge after rst deasserts, with no pushes accepted while rst = 0.

Configuration
REQ-030 SHALL use macro UART_TX_PARITY_EN: when defined, insert state PARITY between DATA and STOP, sending the even-parity bit (XOR of the 8 data bits) for SYMBOL_CYCLES, giving an 11-bit frame; when undefined, omit PARITY, giving a 10-bit frame, and SHALL NOT add parity logic.

Verification (CLOCK_FREQ=40, BAUD_RATE=10, so SYMBOL_CYCLES=4; FIFO_DEPTH=4)
REQ-031 SHALL cover single byte: push 0xA5 at edge N into an idle block -> serial_out low at N+1 for 4 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each, then high; busy low after the stop bit; with UART_TX_PARITY_EN a parity bit 0 precedes the stop bit.
REQ-032 SHALL cover back-to-back: push 0x00 and 0xFF on consecutive edges -> two frames; the second start bit begins on the cycle immediately after the first stop bit's 4th cycle.
REQ-033 SHALL cover full: with data_in_valid held high and bytes 0x01..0x06 offered, exactly 5 bytes are accepted (1 in flight plus 4 queued); data_in_ready is low while fifo_count=4; 0x06 is accepted only after the next pop.
REQ-034 SHALL cover wrap-around: stream 12 sequential bytes 0x10..0x1B with random valid gaps -> the line decodes 0x10..0x1B in order and fifo_count never exceeds 4.
REQ-035 SHALL cover reset mid-frame: assert rst during DATA bit 3 with 2 bytes queued -> serial_out=1 and fifo_count=0 with no clock edge; after release the line stays high and busy=0.
